// File: rtl/cv32e40px_rvfi_trace_buffer.sv
// cv32e40px_rvfi_trace_buffer
// Retirement-trace FIFO between the RVFI retire stage and a trace consumer.
// Up to NRET records per cycle are compacted in channel order into a
// circular buffer. Each record gets a unique order number, and the first
// record after an exception trap or taken interrupt is tagged as a handler
// entry.
// Ports:
//   clk_i, rst_ni (async, active low), clear_i (sync flush)
//   in_*      : per-channel retire records, flattened NRET-wide
//   irq_*     : interrupt taken this cycle and its cause
//   in_ready_o: room for a full NRET push
//   out_*     : head record (all zero when out_valid_o = 0), out_ready_i pops
//   count_o   : occupancy, overflow_o: sticky dropped-push flag
module cv32e40px_rvfi_trace_buffer #(
   parameter int NRET    = 1,
   parameter int DEPTH   = 8,
   parameter int CAUSE_W = 11
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clear_i,
   input  logic [NRET-1:0]         in_valid_i,
   input  logic [NRET*32-1:0]      in_pc_i,
   input  logic [NRET*32-1:0]      in_insn_i,
   input  logic [NRET-1:0]         in_trap_i,
   input  logic [NRET-1:0]         in_exception_i,
   input  logic [NRET-1:0]         in_debug_i,
   input  logic [NRET*CAUSE_W-1:0] in_cause_i,
   input  logic                    irq_taken_i,
   input  logic [CAUSE_W-1:0]      irq_cause_i,
   output logic                    in_ready_o,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [31:0]             out_pc_o,
   output logic [31:0]             out_insn_o,
   output logic                    out_trap_o,
   output logic                    out_exception_o,
   output logic                    out_debug_o,
   output logic [CAUSE_W-1:0]      out_cause_o,
   output logic                    out_intr_o,
   output logic                    out_intr_interrupt_o,
   output logic                    out_intr_exception_o,
   output logic [CAUSE_W-1:0]      out_intr_cause_o,
   output logic [63:0]             out_order_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic                    overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [31:0]        pc;
      logic [31:0]        insn;
      logic               trap;
      logic               exception;
      logic               debug;
      logic [CAUSE_W-1:0] cause;
      logic               intr;
      logic               intr_irq;
      logic               intr_exc;
      logic [CAUSE_W-1:0] intr_cause;
      logic [63:0]        order;
   } rec_t;

   rec_t               mem [DEPTH];
   rec_t               wr_rec [NRET];
   logic [AW-1:0]      wr_off [NRET];
   rec_t               head;

   logic [AW-1:0]      wptr_q, rptr_q;
   logic [CW-1:0]      count_q, push_cnt;
   logic [63:0]        order_q;
   logic               overflow_q;
   logic               pend_v_q, pend_irq_q, pend_exc_q;
   logic [CAUSE_W-1:0] pend_cause_q;

   logic               any_valid, push, drop, pop;
   logic               last_exc;
   logic [CAUSE_W-1:0] last_cause;

   assign any_valid   = |in_valid_i;
   assign in_ready_o  = (count_q <= CW'(DEPTH - NRET));
   assign out_valid_o = (count_q != '0);
   assign push        = in_ready_o & any_valid;
   assign drop        = ~in_ready_o & any_valid;
   assign pop         = out_valid_o & out_ready_i;

   // Walk channels in order: running popcount gives each valid channel its
   // compacted slot; an exception trap tags every later record in the push,
   // otherwise the first record may take the irq or the pending tag.
   always_comb begin
      logic               exc_seen;
      logic               first;
      logic [CW-1:0]      cnt;
      logic [CAUSE_W-1:0] exc_cause;
      exc_seen  = 1'b0;
      first     = 1'b1;
      cnt       = '0;
      exc_cause = '0;
      last_exc  = 1'b0;
      for (int i = 0; i < NRET; i++) begin
         wr_off[i]           = cnt[AW-1:0];
         wr_rec[i].pc        = in_pc_i[i*32 +: 32];
         wr_rec[i].insn      = in_insn_i[i*32 +: 32];
         wr_rec[i].trap      = in_trap_i[i];
         wr_rec[i].exception = in_exception_i[i];
         wr_rec[i].debug     = in_debug_i[i];
         wr_rec[i].cause     = in_cause_i[i*CAUSE_W +: CAUSE_W];
         wr_rec[i].order     = order_q + 64'(cnt);
         wr_rec[i].intr       = 1'b0;
         wr_rec[i].intr_irq   = 1'b0;
         wr_rec[i].intr_exc   = 1'b0;
         wr_rec[i].intr_cause = '0;
         if (exc_seen) begin
            wr_rec[i].intr       = 1'b1;
            wr_rec[i].intr_exc   = 1'b1;
            wr_rec[i].intr_cause = exc_cause;
         end else if (first && irq_taken_i) begin
            wr_rec[i].intr       = 1'b1;
            wr_rec[i].intr_irq   = 1'b1;
            wr_rec[i].intr_cause = irq_cause_i;
         end else if (first && pend_v_q) begin
            wr_rec[i].intr       = 1'b1;
            wr_rec[i].intr_irq   = pend_irq_q;
            wr_rec[i].intr_exc   = pend_exc_q;
            wr_rec[i].intr_cause = pend_cause_q;
         end
         if (in_valid_i[i]) begin
            first    = 1'b0;
            cnt      = cnt + CW'(1);
            last_exc = in_trap_i[i] & in_exception_i[i];
            if (in_trap_i[i] && in_exception_i[i]) begin
               exc_seen  = 1'b1;
               exc_cause = in_cause_i[i*CAUSE_W +: CAUSE_W];
            end
         end
      end
      push_cnt   = cnt;
      last_cause = exc_cause;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q       <= '0;
         rptr_q       <= '0;
         count_q      <= '0;
         order_q      <= '0;
         overflow_q   <= 1'b0;
         pend_v_q     <= 1'b0;
         pend_irq_q   <= 1'b0;
         pend_exc_q   <= 1'b0;
         pend_cause_q <= '0;
      end else if (clear_i) begin
         // order_q deliberately survives a flush so order numbers stay unique
         wptr_q       <= '0;
         rptr_q       <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         pend_v_q     <= 1'b0;
         pend_irq_q   <= 1'b0;
         pend_exc_q   <= 1'b0;
         pend_cause_q <= '0;
      end else begin
         if (push) begin
            wptr_q  <= wptr_q + AW'(push_cnt);
            order_q <= order_q + 64'(push_cnt);
         end
         if (pop) rptr_q <= rptr_q + AW'(1);
         count_q <= count_q + (push ? push_cnt : CW'(0)) - CW'(pop);
         if (drop) overflow_q <= 1'b1;
         if (push && last_exc) begin
            pend_v_q     <= 1'b1;
            pend_irq_q   <= 1'b0;
            pend_exc_q   <= 1'b1;
            pend_cause_q <= last_cause;
         end else if (irq_taken_i && !push) begin
            pend_v_q     <= 1'b1;
            pend_irq_q   <= 1'b1;
            pend_exc_q   <= 1'b0;
            pend_cause_q <= irq_cause_i;
         end else if (push) begin
            pend_v_q     <= 1'b0;
            pend_irq_q   <= 1'b0;
            pend_exc_q   <= 1'b0;
            pend_cause_q <= '0;
         end
      end
   end

   // Storage needs no reset: the head is masked whenever count is zero.
   always_ff @(posedge clk_i) begin
      if (push && !clear_i) begin
         for (int i = 0; i < NRET; i++)
            if (in_valid_i[i]) mem[wptr_q + wr_off[i]] <= wr_rec[i];
      end
   end

   assign head = out_valid_o ? mem[rptr_q] : '0;

   assign out_pc_o             = head.pc;
   assign out_insn_o           = head.insn;
   assign out_trap_o           = head.trap;
   assign out_exception_o      = head.exception;
   assign out_debug_o          = head.debug;
   assign out_cause_o          = head.cause;
   assign out_intr_o           = head.intr;
   assign out_intr_interrupt_o = head.intr_irq;
   assign out_intr_exception_o = head.intr_exc;
   assign out_intr_cause_o     = head.intr_cause;
   assign out_order_o          = head.order;
   assign count_o              = count_q;
   assign overflow_o           = overflow_q;

endmodule

// File: tb/tb_cv32e40px_rvfi_trace_buffer.sv
// Directed bench for cv32e40px_rvfi_trace_buffer (NRET=2, DEPTH=8).
// Stimulus pushes hand-computed expected records into a queue; a monitor
// pops and compares on every accepted head record.
module tb_cv32e40px_rvfi_trace_buffer;
   localparam int NRET = 2, DEPTH = 8, CW = 11;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
      logic        trap, exc, dbg;
      logic [10:0] cause;
      logic        intr, iirq, iexc;
      logic [10:0] icause;
      logic [63:0] order;
   } rec_t;

   logic              clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
   logic [NRET-1:0]   in_valid = '0, in_trap = '0, in_exc = '0, in_dbg = '0;
   logic [NRET*32-1:0] in_pc = '0, in_insn = '0;
   logic [NRET*CW-1:0] in_cause = '0;
   logic              irq_taken = 1'b0;
   logic [CW-1:0]     irq_cause = '0;
   logic              in_ready, out_valid, out_ready = 1'b0;
   logic [31:0]       out_pc, out_insn;
   logic              out_trap, out_exc, out_dbg;
   logic [CW-1:0]     out_cause, out_icause;
   logic              out_intr, out_iirq, out_iexc;
   logic [63:0]       out_order;
   logic [3:0]        count;
   logic              overflow;

   int   tests = 0, fails = 0;
   rec_t exp_q[$];

   always #5 clk = ~clk;

   cv32e40px_rvfi_trace_buffer #(.NRET(NRET), .DEPTH(DEPTH), .CAUSE_W(CW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
      .in_valid_i(in_valid), .in_pc_i(in_pc), .in_insn_i(in_insn),
      .in_trap_i(in_trap), .in_exception_i(in_exc), .in_debug_i(in_dbg),
      .in_cause_i(in_cause), .irq_taken_i(irq_taken), .irq_cause_i(irq_cause),
      .in_ready_o(in_ready), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_pc_o(out_pc), .out_insn_o(out_insn), .out_trap_o(out_trap),
      .out_exception_o(out_exc), .out_debug_o(out_dbg), .out_cause_o(out_cause),
      .out_intr_o(out_intr), .out_intr_interrupt_o(out_iirq),
      .out_intr_exception_o(out_iexc), .out_intr_cause_o(out_icause),
      .out_order_o(out_order), .count_o(count), .overflow_o(overflow)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      in_valid = '0; in_trap = '0; in_exc = '0; in_dbg = '0; in_cause = '0;
      irq_taken = 1'b0; irq_cause = '0; clear = 1'b0;
   endtask

   task automatic drv(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
      in_valid = v;
      in_pc    = {p1, p0};
      in_insn  = {~p1, ~p0};
   endtask

   // tf = {trap, exception, debug}; tg = {intr, interrupt, exception}
   task automatic exp_rec(input logic [31:0] pc, input logic [63:0] ord,
                          input logic [2:0] tf, input logic [10:0] c,
                          input logic [2:0] tg, input logic [10:0] ic);
      rec_t r;
      r.pc = pc; r.insn = ~pc; {r.trap, r.exc, r.dbg} = tf; r.cause = c;
      {r.intr, r.iirq, r.iexc} = tg; r.icause = ic; r.order = ord;
      exp_q.push_back(r);
   endtask

   task automatic drain(input int n);
      out_ready = 1'b1;
      repeat (n) tick();
      out_ready = 1'b0;
   endtask

   // Monitor: compare every head record the consumer accepts.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         rec_t act, req;
         act.pc = out_pc; act.insn = out_insn; act.trap = out_trap;
         act.exc = out_exc; act.dbg = out_dbg; act.cause = out_cause;
         act.intr = out_intr; act.iirq = out_iirq; act.iexc = out_iexc;
         act.icause = out_icause; act.order = out_order;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rec_unexpected: got pc=%0h order=%0d expected no record", out_pc, out_order);
         end else begin
            req = exp_q.pop_front();
            if (act !== req) begin
               fails++;
               $display("FAIL rec pc=%0h: got %0h expected %0h", req.pc, act, req);
            end
         end
      end
   end

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 64'(count), 0);
      chk("rst_valid", 64'(out_valid), 0);
      chk("rst_overflow", 64'(overflow), 0);
      chk("rst_in_ready", 64'(in_ready), 1);
      chk("rst_out_pc", 64'(out_pc), 0);
      chk("rst_out_order", out_order, 0);
      rst_n = 1'b1;
      tick();

      // single-entry flow, no fall-through
      drv(2'b01, 32'h100, 0);
      exp_rec(32'h100, 0, 0, 0, 0, 0);
      chk("t1_no_fallthru", 64'(out_valid), 0);
      tick();
      chk("t1_valid", 64'(out_valid), 1);
      chk("t1_count", 64'(count), 1);
      chk("t1_pc", 64'(out_pc), 64'h100);
      chk("t1_order", out_order, 0);
      drain(1);
      chk("t1_count_after_pop", 64'(count), 0);
      chk("t1_valid_after_pop", 64'(out_valid), 0);
      chk("t1_pc_zero", 64'(out_pc), 0);
      chk("t1_insn_zero", 64'(out_insn), 0);

      // compaction
      drv(2'b10, 0, 32'h200);
      exp_rec(32'h200, 1, 0, 0, 0, 0);
      tick();
      drv(2'b11, 32'h300, 32'h304);
      exp_rec(32'h300, 2, 0, 0, 0, 0);
      exp_rec(32'h304, 3, 0, 0, 0, 0);
      tick();
      chk("t2_count", 64'(count), 3);
      drain(3);
      chk("t2_count_drained", 64'(count), 0);

      // exception tagging, same push and next push; debug traps never tag
      drv(2'b11, 32'h400, 32'h404);
      in_trap = 2'b01; in_exc = 2'b01; in_cause = {11'd0, 11'd2};
      exp_rec(32'h400, 4, 3'b110, 2, 0, 0);
      exp_rec(32'h404, 5, 0, 0, 3'b101, 2);
      tick();
      drv(2'b01, 32'h500, 0);
      in_trap = 2'b01; in_exc = 2'b01; in_cause = {11'd0, 11'd5};
      exp_rec(32'h500, 6, 3'b110, 5, 0, 0);
      tick();
      drv(2'b01, 32'h504, 0);
      exp_rec(32'h504, 7, 0, 0, 3'b101, 5);
      tick();
      drv(2'b01, 32'h508, 0);
      exp_rec(32'h508, 8, 0, 0, 0, 0);
      tick();
      drv(2'b01, 32'h600, 0);
      in_trap = 2'b01; in_dbg = 2'b01; in_cause = {11'd0, 11'd3};
      exp_rec(32'h600, 9, 3'b101, 3, 0, 0);
      tick();
      drv(2'b01, 32'h604, 0);
      exp_rec(32'h604, 10, 0, 0, 0, 0);
      tick();
      chk("t3_count7", 64'(count), 7);
      chk("t3_not_ready_at7", 64'(in_ready), 0);
      drain(7);

      // interrupt tagging: newer pending irq wins, same-cycle irq tags push
      irq_taken = 1'b1; irq_cause = 11'd11;
      tick();
      irq_taken = 1'b1; irq_cause = 11'd7;
      tick();
      drv(2'b01, 32'h700, 0);
      exp_rec(32'h700, 11, 0, 0, 3'b110, 7);
      tick();
      drv(2'b01, 32'h704, 0);
      exp_rec(32'h704, 12, 0, 0, 0, 0);
      tick();
      drv(2'b11, 32'h800, 32'h804);
      irq_taken = 1'b1; irq_cause = 11'd9;
      exp_rec(32'h800, 13, 0, 0, 3'b110, 9);
      exp_rec(32'h804, 14, 0, 0, 0, 0);
      tick();
      drain(4);

      // fill to full, dropped push, sticky overflow, clear
      for (int k = 0; k < 4; k++) begin
         drv(2'b11, 32'h900 + 32'(16 * k), 32'h904 + 32'(16 * k));
         exp_rec(32'h900 + 32'(16 * k), 64'(15 + 2 * k), 0, 0, 0, 0);
         exp_rec(32'h904 + 32'(16 * k), 64'(16 + 2 * k), 0, 0, 0, 0);
         tick();
         if (k == 2) chk("t5_ready_at6", 64'(in_ready), 1);
      end
      chk("t5_count_full", 64'(count), 8);
      chk("t5_not_ready_full", 64'(in_ready), 0);
      chk("t5_valid_full", 64'(out_valid), 1);
      chk("t5_no_overflow_yet", 64'(overflow), 0);
      drv(2'b01, 32'hBAD, 0);
      tick();
      chk("t5_overflow_set", 64'(overflow), 1);
      chk("t5_count_after_drop", 64'(count), 8);
      drain(8);
      chk("t5_drained", 64'(count), 0);
      chk("t5_overflow_sticky", 64'(overflow), 1);
      clear = 1'b1;
      tick();
      chk("t5_overflow_cleared", 64'(overflow), 0);

      // simultaneous push+pop keeps count; clear beats push; order survives clear
      for (int k = 0; k < 3; k++) begin
         drv(2'b11, 32'hA00 + 32'(16 * k), 32'hA04 + 32'(16 * k));
         exp_rec(32'hA00 + 32'(16 * k), 64'(23 + 2 * k), 0, 0, 0, 0);
         exp_rec(32'hA04 + 32'(16 * k), 64'(24 + 2 * k), 0, 0, 0, 0);
         tick();
      end
      drv(2'b01, 32'hA30, 0);
      exp_rec(32'hA30, 29, 0, 0, 0, 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t6_count_pushpop", 64'(count), 6);
      clear = 1'b1;
      drv(2'b11, 32'hB00, 32'hB04);
      tick();
      exp_q.delete();
      chk("t6_count_cleared", 64'(count), 0);
      chk("t6_valid_cleared", 64'(out_valid), 0);
      drv(2'b01, 32'hC00, 0);
      exp_rec(32'hC00, 30, 0, 0, 0, 0);
      tick();
      chk("t6_order_kept", out_order, 30);
      drain(1);

      // asynchronous reset mid-operation
      drv(2'b01, 32'hD00, 0);
      tick();
      chk("t7_count_before_rst", 64'(count), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t7_count_async_rst", 64'(count), 0);
      chk("t7_valid_async_rst", 64'(out_valid), 0);
      #1 rst_n = 1'b1;
      tick();
      drv(2'b01, 32'hE00, 0);
      exp_rec(32'hE00, 0, 0, 0, 0, 0);
      tick();
      drain(1);

      chk("queue_empty", 64'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/cv32e40px_rvfi_trace_buffer.md
# cv32e40px_rvfi_trace_buffer

Parametrised retirement-trace buffer between the core's RVFI retire stage and the trace/verification consumer. It accepts up to NRET retired-instruction records per cycle and compacts them in channel order into a circular FIFO. It attaches a unique order number and trap/interrupt information to each record. It also tags the first record after an exception or taken interrupt as a handler entry, which the single-cycle RVFI struct set cannot express.

## Interface
- NRET, 1: retire channels per cycle; 1..4.
- DEPTH, 8: FIFO entries; power of two, ≥ 2*NRET.
- CAUSE_W, 11: cause field width.
- clk_i  in  1  clock.
- rst_ni  in  1  reset. Asynchronous, active-low.
- clear_i  in  1  synchronous flush.
- in_valid_i  in  NRET  per-channel record valid.
- in_pc_i  in  NRET*32  per-channel PC.
- in_insn_i  in  NRET*32  per-channel instruction word.
- in_trap_i / in_exception_i / in_debug_i  in  NRET each  trap flags per channel.
- in_cause_i  in  NRET*CAUSE_W  trap cause per channel.
- irq_taken_i  in  1  interrupt taken this cycle.
- irq_cause_i  in  CAUSE_W  cause of the taken interrupt.
- in_ready_o  out  1  buffer can accept a full NRET push.
- out_valid_o  out  1  head record valid.
- out_ready_i  in  1  consumer accepts the head.
- out_pc_o, out_insn_o  out  32 each  head PC and instruction word.
- out_trap_o, out_exception_o, out_debug_o  out  1 each  head trap flags.
- out_cause_o  out  CAUSE_W  head trap cause.
- out_intr_o, out_intr_interrupt_o, out_intr_exception_o  out  1 each  handler-entry tag.
- out_intr_cause_o  out  CAUSE_W  handler-entry cause.
- out_order_o  out  64  record order number.
- count_o  out  $clog2(DEPTH)+1  occupancy.
- overflow_o  out  1  sticky drop indicator.

## Operation
- Reset values:
  - count_o = 0, out_valid_o = 0, overflow_o = 0, in_ready_o = 1.
  - All out_* data outputs are 0.
  - Order counter = 0; pending tag cleared.
- Whenever out_valid_o = 0, all out_* data outputs are forced to 0.
- Push fires when in_ready_o = 1 and any in_valid_i bit is set.
  - Valid channels are written in ascending channel index at consecutive write pointers; gaps are compacted.
  - Write pointer advances by popcount(in_valid_i).
  - Each written record takes the current order value; the order counter advances by the same popcount and wraps at 2^64.
- Dropped push: any in_valid_i bit set while in_ready_o = 0.
  - Nothing is written and the order counter does not advance.
  - overflow_o is set and stays set until clear_i or reset.
- Pop fires when out_valid_o = 1 and out_ready_i = 1; the read pointer advances by 1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Tag sources, in priority order, for each written record:
  - A preceding record in the same push has in_trap_i = 1 and in_exception_i = 1: tag with exception = 1, cause = that record's in_cause_i.
  - For the first written record only, irq_taken_i = 1: tag with interrupt = 1, cause = irq_cause_i.
  - For the first written record only, a pending tag is present: use the pending tag.
  - Otherwise the record's intr fields are 0.
- Pending tag register {valid, interrupt, exception, cause}, updated at the end of each cycle:
  - If the last written exception-trap record in the push has no later record in that push, pending becomes the exception tag for that record.
  - Else, if irq_taken_i = 1 with no push, pending becomes the interrupt tag for irq_cause_i. A newer interrupt overwrites an older pending tag.
  - Else, if a push consumed the pending tag, pending is cleared.
- Debug traps (in_debug_i) are stored but never generate a tag.
- clear_i empties the FIFO and clears the pending tag and overflow_o.
  - The order counter is not reset by clear_i, so order numbers stay unique.
  - clear_i has priority over a same-cycle push or pop; both are ignored.

## Timing
- in_ready_o = (count ≤ DEPTH − NRET), computed from the registered count only. There is no combinational path from out_ready_i to in_ready_o.
- A record pushed in cycle N is visible at the head in cycle N+1 at the earliest. There is no fall-through.
- Simultaneous push and pop: count_next = count + popcount − 1. Storage is DEPTH deep, so the written and read entries never collide.
- Full: count = DEPTH. out_valid_o stays 1 and in_ready_o = 0.
- Empty: count = 0. out_valid_o = 0 and out_ready_i is ignored.
- Asynchronous reset mid-operation: all state returns to reset values immediately; records already stored are lost.

## Test plan
- Single-entry flow, NRET=1, DEPTH=8: push pc=0x100 → out_valid_o = 1 next cycle; out_order_o = 0, out_pc_o = 0x100. Pop → count_o = 0 and outputs read 0.
- Fill to full: push 8 records with out_ready_i = 0 → in_ready_o = 0 at count 8. A ninth push is dropped and sets overflow_o = 1. Drain → orders read 0..7 in order and overflow_o stays 1 until clear_i.
- Compaction, NRET=2: in_valid_i = 2'b10 with pc=0x200, then 2'b11 with pc=0x300/0x304 → FIFO order 0x200, 0x300, 0x304 with orders 0, 1, 2.
- Exception tagging, NRET=2: channel 0 trap/exception cause 2 and channel 1 valid in the same push → channel 1 record has out_intr_o = 1, out_intr_exception_o = 1, out_intr_cause_o = 2. With channel 1 invalid, the next cycle's first record carries the same tag.
- Interrupt tagging: irq_taken_i = 1, cause 11, with no push, then irq cause 7, then a push → that record is tagged with interrupt = 1 and cause 7. The following record is untagged.
- Simultaneous push and pop at count = DEPTH−1 → count_o unchanged. Asserting clear_i with a same-cycle push gives count_o = 0, and the order counter is not reset.
